// File: rtl/ram_rd_resp_buffer.sv
// RAM read-response buffer: a small FIFO for RAM read data, with upstream read
// credits so that every launched read is guaranteed a free slot for its response.
module ram_rd_resp_buffer #(
  parameter int DATA_WIDTH  = 32,
  parameter int RAM_LATENCY = 2,
  parameter int DEPTH       = 4,
  localparam int CNT_W      = $clog2(DEPTH + 1)
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic                  rd_en_i,
  output logic                  rd_ready_o,
  input  logic [DATA_WIDTH-1:0] rd_data_i,
  input  logic                  rd_data_val_i,
  output logic [DATA_WIDTH-1:0] out_data_o,
  output logic                  out_valid_o,
  input  logic                  out_ready_i,
  output logic [CNT_W-1:0]      used_o,
  output logic                  overflow_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [CNT_W-1:0] FULL_CNT  = CNT_W'(DEPTH);
  localparam logic [CNT_W:0]   CREDITS   = (CNT_W + 1)'(DEPTH);
  localparam logic [PTR_W-1:0] LAST_SLOT = PTR_W'(DEPTH - 1);

  if (DEPTH < 1) begin : g_depth_fatal
    $fatal(1, "ram_rd_resp_buffer: DEPTH must be at least 1");
  end
  if (DEPTH < RAM_LATENCY) begin : g_depth_warn
    $warning("ram_rd_resp_buffer: DEPTH < RAM_LATENCY, back-to-back reads will stall");
  end

  // Handshakes: consumer transfer when out_valid_o & out_ready_i on a rising
  // edge; upstream may launch a read (rd_en_i) only in a cycle where rd_ready_o=1.
  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0]      wr_ptr, rd_ptr;
  logic [CNT_W-1:0]      count, in_flight;
  logic                  overflow;
  logic [CNT_W:0]        credits_used;
  logic                  pop, drop, push, illegal_rd, underflow;

  function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
    return (p == LAST_SLOT) ? '0 : p + 1'b1;
  endfunction

  // Credit check uses registered state only, so rd_ready_o has no input path.
  assign credits_used = {1'b0, in_flight} + {1'b0, count};
  assign rd_ready_o   = credits_used < CREDITS;

  assign pop        = (count != '0) && out_ready_i;
  assign drop       = rd_data_val_i && (count == FULL_CNT);
  assign push       = rd_data_val_i && !drop;
  assign illegal_rd = rd_en_i && !rd_ready_o;
  assign underflow  = rd_data_val_i && !rd_en_i && (in_flight == '0);

  always_ff @(posedge clk_i) begin
    if (push) mem[wr_ptr] <= rd_data_i;
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr    <= '0;
      rd_ptr    <= '0;
      count     <= '0;
      in_flight <= '0;
      overflow  <= 1'b0;
    end else begin
      if (push) wr_ptr <= next_ptr(wr_ptr);
      if (pop)  rd_ptr <= next_ptr(rd_ptr);

      case ({push, pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase

      // Saturating: an illegal read still counts because the RAM will answer it.
      if (rd_en_i && !rd_data_val_i && (in_flight != '1))
        in_flight <= in_flight + 1'b1;
      else if (!rd_en_i && rd_data_val_i && (in_flight != '0))
        in_flight <= in_flight - 1'b1;

      if (illegal_rd || drop || underflow) overflow <= 1'b1;
    end
  end

  assign out_valid_o = (count != '0);
  assign out_data_o  = mem[rd_ptr];
  assign used_o      = count;
  assign overflow_o  = overflow;

endmodule

// File: tb/tb_ram_rd_resp_buffer.sv
// Bench for ram_rd_resp_buffer: DEPTH=4 instance checked every cycle against a
// queue model, plus a DEPTH=3 instance checked for in-order delivery.
module tb_ram_rd_resp_buffer;

  localparam int DW    = 32;
  localparam int LAT   = 2;
  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);
  localparam int CW3   = $clog2(3 + 1);

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------- DEPTH=4 instance ----------------
  logic          rd_en_i = 1'b0, rd_data_val_i = 1'b0, out_ready_i = 1'b0;
  logic [DW-1:0] rd_data_i = '0;
  logic          rd_ready_o, out_valid_o, overflow_o;
  logic [DW-1:0] out_data_o;
  logic [CW-1:0] used_o;

  ram_rd_resp_buffer #(.DATA_WIDTH(DW), .RAM_LATENCY(LAT), .DEPTH(DEPTH)) dut (
    .clk_i(clk), .rst_i(rst), .rd_en_i(rd_en_i), .rd_ready_o(rd_ready_o),
    .rd_data_i(rd_data_i), .rd_data_val_i(rd_data_val_i),
    .out_data_o(out_data_o), .out_valid_o(out_valid_o), .out_ready_i(out_ready_i),
    .used_o(used_o), .overflow_o(overflow_o)
  );

  // ---------------- DEPTH=3 instance ----------------
  logic           e3 = 1'b0, v3 = 1'b0, r3 = 1'b0;
  logic [DW-1:0]  d3 = '0;
  logic           rdy3, val3, ovf3;
  logic [DW-1:0]  q3;
  logic [CW3-1:0] used3;

  ram_rd_resp_buffer #(.DATA_WIDTH(DW), .RAM_LATENCY(LAT), .DEPTH(3)) dut3 (
    .clk_i(clk), .rst_i(rst), .rd_en_i(e3), .rd_ready_o(rdy3),
    .rd_data_i(d3), .rd_data_val_i(v3),
    .out_data_o(q3), .out_valid_o(val3), .out_ready_i(r3),
    .used_o(used3), .overflow_o(ovf3)
  );

  // ---------------- scoreboard counters ----------------
  int n_chk  = 0;
  int n_fail = 0;

  function automatic void check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endfunction

  // ---------------- behavioural model (DEPTH=4) ----------------
  logic [DW-1:0] exp_q[$];
  int            m_inf = 0;
  logic          m_ovf = 1'b0;

  function automatic logic model_ready();
    return (m_inf + exp_q.size()) < DEPTH;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      exp_q.delete();
      m_inf = 0;
      m_ovf = 1'b0;
    end else begin
      int  sz;
      logic do_pop;
      sz     = exp_q.size();
      do_pop = (sz != 0) && out_ready_i;
      if (rd_en_i && !model_ready()) m_ovf = 1'b1;
      if (rd_data_val_i && sz == DEPTH) m_ovf = 1'b1;
      if (rd_en_i && !rd_data_val_i) begin
        if (m_inf < (2 ** CW) - 1) m_inf++;
      end else if (!rd_en_i && rd_data_val_i) begin
        if (m_inf == 0) m_ovf = 1'b1;
        else m_inf--;
      end
      if (do_pop) void'(exp_q.pop_front());
      if (rd_data_val_i && sz < DEPTH) exp_q.push_back(rd_data_i);
    end
  end

  // Per-cycle compare of every DEPTH=4 output against the model.
  always @(negedge clk) begin
    check("rd_ready", 32'(rd_ready_o), 32'(model_ready()));
    check("out_valid", 32'(out_valid_o), 32'(exp_q.size() != 0));
    check("used", 32'(used_o), 32'(exp_q.size()));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    if (exp_q.size() != 0) check("out_data", out_data_o, exp_q[0]);
  end

  // ---------------- RAM model and driver tasks ----------------
  logic          vq[$];
  logic [DW-1:0] dq[$];
  logic [DW-1:0] rx_q[$];
  logic [DW-1:0] word = 32'hA0;
  logic          inj = 1'b0;

  task automatic clear_pipe();
    vq.delete();
    dq.delete();
    for (int i = 0; i < LAT; i++) begin
      vq.push_back(1'b0);
      dq.push_back('0);
    end
  endtask

  // Called at a falling edge; returns at the next falling edge.
  task automatic step(input logic en, input logic ordy);
    rd_en_i       = en;
    out_ready_i   = ordy;
    rd_data_val_i = vq[0] | inj;
    rd_data_i     = inj ? 32'h55 : dq[0];
    if (out_valid_o && ordy) rx_q.push_back(out_data_o);
    @(posedge clk);
    void'(vq.pop_front());
    void'(dq.pop_front());
    vq.push_back(en);
    dq.push_back(en ? word : '0);
    if (en) word = word + 1;
    @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- main sequence ----------------
  initial begin
    int first_v, max_used, sent, acc, rx3, sent3;
    logic [DW-1:0] first_fill;
    logic [DW-1:0] exp3_q[$];
    logic          vq3[$];
    logic [DW-1:0] dq3[$];

    clear_pipe();
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("reset_ready", 32'(rd_ready_o), 32'd1);
    check("reset_valid", 32'(out_valid_o), 32'd0);
    check("reset_used", 32'(used_o), 32'd0);
    check("reset_ovf", 32'(overflow_o), 32'd0);

    // Streaming at full rate: first output 3 cycles after first read.
    first_v = -1; max_used = 0; sent = 0;
    rx_q.delete();
    for (int i = 0; i < 20; i++) begin
      if (out_valid_o && first_v < 0) first_v = i;
      if (int'(used_o) > max_used) max_used = int'(used_o);
      if (sent < 12 && model_ready()) begin
        sent++;
        step(1'b1, 1'b1);
      end else begin
        step(1'b0, 1'b1);
      end
    end
    check("stream_first_valid", 32'(first_v), 32'd3);
    check("stream_max_used", 32'(max_used), 32'd1);
    check("stream_count", 32'(rx_q.size()), 32'd12);
    for (int k = 0; k < rx_q.size(); k++) check("stream_order", rx_q[k], 32'hA0 + 32'(k));

    // Fill with consumer stalled: exactly DEPTH reads accepted.
    first_fill = word;
    acc = 0;
    for (int i = 0; i < 8; i++) begin
      if (model_ready()) begin
        acc++;
        step(1'b1, 1'b0);
      end else begin
        step(1'b0, 1'b0);
      end
    end
    check("fill_accepted", 32'(acc), 32'd4);
    check("fill_used", 32'(used_o), 32'd4);
    check("fill_ready", 32'(rd_ready_o), 32'd0);
    check("fill_head", out_data_o, first_fill);
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    check("fill_head_stable", out_data_o, first_fill);

    // One pop frees one credit; a new read lands at the tail.
    step(1'b0, 1'b1);
    check("pop_used", 32'(used_o), 32'd3);
    check("pop_ready", 32'(rd_ready_o), 32'd1);
    step(1'b1, 1'b0);
    repeat (3) step(1'b0, 1'b0);
    check("refill_used", 32'(used_o), 32'd4);
    rx_q.delete();
    repeat (5) step(1'b0, 1'b1);
    check("refill_count", 32'(rx_q.size()), 32'd4);
    for (int k = 0; k < rx_q.size(); k++) check("refill_order", rx_q[k], first_fill + 32'(k + 1));

    // Random legal traffic.
    for (int i = 0; i < 300; i++)
      step(model_ready() && ($urandom_range(0, 3) != 0), 1'($urandom_range(0, 1)));
    repeat (6) step(1'b0, 1'b1);
    check("random_ovf", 32'(overflow_o), 32'd0);

    // Illegal read into a full buffer; its response arrives with a pop and is dropped.
    for (int i = 0; i < 6; i++) step(model_ready(), 1'b0);
    repeat (3) step(1'b0, 1'b0);
    check("ovf_pre_used", 32'(used_o), 32'd4);
    step(1'b1, 1'b0);
    check("ovf_illegal_rd", 32'(overflow_o), 32'd1);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
    check("drop_used", 32'(used_o), 32'd3);
    repeat (5) step(1'b0, 1'b1);
    check("ovf_sticky", 32'(overflow_o), 32'd1);
    check("drain_used", 32'(used_o), 32'd0);

    // Asynchronous reset in the middle of a burst.
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    step(1'b1, 1'b0);
    #2 rst = 1'b1;
    #1;
    check("async_ready", 32'(rd_ready_o), 32'd1);
    check("async_valid", 32'(out_valid_o), 32'd0);
    check("async_used", 32'(used_o), 32'd0);
    check("async_ovf", 32'(overflow_o), 32'd0);
    rd_en_i = 1'b0; rd_data_val_i = 1'b0; out_ready_i = 1'b0;
    clear_pipe();
    @(negedge clk);
    rst = 1'b0;

    // Response with nothing in flight: underflow flagged, word still buffered.
    inj = 1'b1;
    step(1'b0, 1'b0);
    inj = 1'b0;
    check("underflow_ovf", 32'(overflow_o), 32'd1);
    check("underflow_used", 32'(used_o), 32'd1);
    check("underflow_data", out_data_o, 32'h55);
    step(1'b0, 1'b1);
    step(1'b0, 1'b1);
    rd_en_i = 1'b0; rd_data_val_i = 1'b0; out_ready_i = 1'b0;

    // DEPTH=3: ten reads under random back-pressure, delivered in order.
    rx3 = 0; sent3 = 0;
    for (int i = 0; i < LAT; i++) begin
      vq3.push_back(1'b0);
      dq3.push_back('0);
    end
    for (int i = 0; i < 200 && rx3 < 10; i++) begin
      e3 = (sent3 < 10) && rdy3;
      r3 = 1'($urandom_range(0, 1));
      v3 = vq3[0];
      d3 = dq3[0];
      if (val3 && r3) begin
        if (exp3_q.size() == 0) begin
          check("d3_unexpected_word", q3, 32'hFFFF_FFFF);
        end else begin
          check("d3_order", q3, exp3_q.pop_front());
        end
        rx3++;
      end
      if (int'(used3) > 3) check("d3_used_bound", 32'(used3), 32'd3);
      @(posedge clk);
      void'(vq3.pop_front());
      void'(dq3.pop_front());
      vq3.push_back(e3);
      dq3.push_back(e3 ? 32'hB0 + 32'(sent3) : '0);
      if (e3) begin
        exp3_q.push_back(32'hB0 + 32'(sent3));
        sent3++;
      end
      @(negedge clk);
    end
    e3 = 1'b0; v3 = 1'b0; r3 = 1'b0;
    check("d3_received", 32'(rx3), 32'd10);
    check("d3_ovf", 32'(ovf3), 32'd0);
    check("d3_used_end", 32'(used3), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
